// File: rtl/uart_receiver.sv
// UART receive stage: recovers 8N1/8E1/8O1 frames from an asynchronous rx line
// and presents each byte with a one-cycle valid strobe plus parity/framing flags.
module uart_receiver #(
    parameter int BRCLOCK_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       pen,
    input  logic       peven,
    output logic [7:0] dout,
    output logic       valid,
    output logic       perr,
    output logic       ferr,
    output logic       busy
);

    localparam int CW   = $clog2(BRCLOCK_CYCLES);
    localparam int HALF = BRCLOCK_CYCLES / 2;
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(BRCLOCK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          rx_meta;
    logic          rx_s;
    logic          rx_d;
    logic          pen_l;
    logic          peven_l;
    logic          par_err;
    logic          stop_bit;
    logic          stop_done;

    // Synchronizer and edge register idle high so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            pen_l     <= 1'b0;
            peven_l   <= 1'b0;
            par_err   <= 1'b0;
            stop_bit  <= 1'b1;
            stop_done <= 1'b0;
            dout      <= '0;
            valid     <= 1'b0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt       <= '0;
                    stop_done <= 1'b0;
                    if (rx_d && !rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            pen_l   <= pen;
                            peven_l <= peven;
                            idx     <= '0;
                            state   <= DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == BIT_M1) begin
                        cnt        <= '0;
                        shreg[idx] <= rx_s;
                        idx        <= idx + 1'b1;
                        if (idx == 3'd7) begin
                            state <= pen_l ? PARITY : STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                PARITY: begin
                    if (cnt == BIT_M1) begin
                        cnt     <= '0;
                        // Odd parity expects the inverted XOR, hence the ~peven_l term.
                        par_err <= rx_s ^ (^shreg) ^ ~peven_l;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (stop_done) begin
                        dout      <= shreg;
                        perr      <= pen_l & par_err;
                        ferr      <= ~stop_bit;
                        valid     <= 1'b1;
                        busy      <= 1'b0;
                        stop_done <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else if (cnt == BIT_M1) begin
                        cnt       <= '0;
                        stop_bit  <= rx_s;
                        stop_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    stop_done <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table vectors, hand-written corner cases
// and randomized frames checked against a bit-counting reference model.
module tb_uart_receiver;

    localparam int B = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       pen = 1'b0;
    logic       peven = 1'b0;
    logic [7:0] dout;
    logic       valid;
    logic       perr;
    logic       ferr;
    logic       busy;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int valid_count = 0;
    int frames_expected = 0;
    bit prev_valid = 1'b0;

    typedef struct {
        logic [7:0] dout;
        logic       perr;
        logic       ferr;
        int         at;
    } obs_t;

    obs_t obsq[$];

    typedef struct {
        logic [7:0] data;
        bit         pen;
        bit         peven;
        bit         par_bit;
        bit         stop_bit;
        logic [7:0] exp_dout;
        bit         exp_perr;
        bit         exp_ferr;
    } vec_t;

    vec_t vecs[7];

    uart_receiver #(.BRCLOCK_CYCLES(B)) dut (
        .clk   (clk),
        .rst   (rst),
        .rx    (rx),
        .pen   (pen),
        .peven (peven),
        .dout  (dout),
        .valid (valid),
        .perr  (perr),
        .ferr  (ferr),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every valid pulse is captured here; the tests pop and compare in order.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            obs_t o;
            check_output("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
            o.dout = dout;
            o.perr = perr;
            o.ferr = ferr;
            o.at   = cyc;
            obsq.push_back(o);
            valid_count++;
        end
        prev_valid = (valid === 1'b1);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit model_parity_bit(input logic [7:0] d, input bit even);
        int ones;
        ones = $countones(d);
        return even ? bit'(ones % 2) : bit'((ones + 1) % 2);
    endfunction

    function automatic bit model_perr(input logic [7:0] d, input bit pen_i, input bit peven_i, input bit par_bit);
        int total;
        if (!pen_i) return 1'b0;
        total = $countones(d) + int'(par_bit);
        return peven_i ? (total % 2 != 0) : (total % 2 == 0);
    endfunction

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        ticks(n);
    endtask

    // Drives one frame LSB first; the line is left at the stop-bit level.
    task automatic apply_stimulus(input logic [7:0] d, input bit pen_i, input bit peven_i,
                                  input bit par_bit, input bit stop_b);
        pen   = pen_i;
        peven = peven_i;
        rx    = 1'b0;
        ticks(B);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            ticks(B);
        end
        if (pen_i) begin
            rx = par_bit;
            ticks(B);
        end
        rx = stop_b;
        ticks(B);
    endtask

    task automatic expect_frame(input string name, input logic [7:0] exp_d, input bit exp_p,
                                input bit exp_f, output int at);
        int waited;
        obs_t o;
        waited = 0;
        at = -1;
        frames_expected++;
        while (obsq.size() == 0 && waited < 5 * B) begin
            @(negedge clk);
            waited++;
        end
        if (obsq.size() == 0) begin
            checks++;
            $display("[TB] FAIL %s.timeout: got no valid, expected one valid pulse", name);
        end else begin
            o  = obsq.pop_front();
            at = o.at;
            check_output($sformatf("%s.dout", name), {24'd0, o.dout}, {24'd0, exp_d});
            check_output($sformatf("%s.perr", name), {31'd0, o.perr}, {31'd0, exp_p});
            check_output($sformatf("%s.ferr", name), {31'd0, o.ferr}, {31'd0, exp_f});
        end
    endtask

    initial begin
        int start_cyc;
        int at;
        int vc;
        bit busy_seen;
        logic [7:0] d;
        bit p_i, pe_i, pb, sb;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
        vecs[3] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[4] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0};
        vecs[5] = '{8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1};
        vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};

        #12;
        check_output("reset.dout", {24'd0, dout}, 32'd0);
        check_output("reset.valid", {31'd0, valid}, 32'd0);
        check_output("reset.perr", {31'd0, perr}, 32'd0);
        check_output("reset.ferr", {31'd0, ferr}, 32'd0);
        check_output("reset.busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(2 * B);

        // Latency from the rx falling edge to valid, without and with parity.
        start_cyc = cyc;
        apply_stimulus(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2 * B);
        expect_frame("lat_np", 8'hA5, 1'b0, 1'b0, at);
        check_output("lat_np.cycles", at - start_cyc, 3 + B / 2 + 9 * B + 1);
        check_output("lat_np.busy_after", {31'd0, busy}, 32'd0);
        start_cyc = cyc;
        apply_stimulus(8'h3E, 1'b1, 1'b0, model_parity_bit(8'h3E, 1'b0), 1'b1);
        idle(2 * B);
        expect_frame("lat_p", 8'h3E, 1'b0, 1'b0, at);
        check_output("lat_p.cycles", at - start_cyc, 3 + B / 2 + 10 * B + 1);

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i].data, vecs[i].pen, vecs[i].peven, vecs[i].par_bit, vecs[i].stop_bit);
            idle(2 * B);
            expect_frame($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_perr, vecs[i].exp_ferr, at);
            check_output($sformatf("vec%0d.busy", i), {31'd0, busy}, 32'd0);
        end

        // Three-cycle glitch: a false start that must not produce a frame.
        vc = valid_count;
        rx = 1'b0;
        ticks(3);
        rx = 1'b1;
        busy_seen = 1'b0;
        for (int i = 0; i < 2 * B; i++) begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
        end
        check_output("glitch.busy_seen", {31'd0, busy_seen}, 32'd1);
        check_output("glitch.busy_end", {31'd0, busy}, 32'd0);
        check_output("glitch.no_valid", valid_count, vc);
        apply_stimulus(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2 * B);
        expect_frame("after_glitch", 8'h3C, 1'b0, 1'b0, at);

        // Framing error followed by a line held low: no retrigger.
        apply_stimulus(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_frame("ferr_low", 8'h55, 1'b0, 1'b1, at);
        vc = valid_count;
        busy_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
        end
        check_output("held_low.busy_seen", {31'd0, busy_seen}, 32'd0);
        check_output("held_low.no_valid", valid_count, vc);
        idle(2 * B);
        apply_stimulus(8'h96, 1'b1, 1'b1, model_parity_bit(8'h96, 1'b1), 1'b1);
        idle(2 * B);
        expect_frame("after_low", 8'h96, 1'b0, 1'b0, at);

        // Asynchronous reset in the middle of data bit 3 of 0xFF.
        vc = valid_count;
        pen = 1'b0;
        rx = 1'b0;
        ticks(B);
        rx = 1'b1;
        ticks(3 * B + B / 2);
        check_output("midreset.busy_before", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_output("midreset.dout", {24'd0, dout}, 32'd0);
        check_output("midreset.valid", {31'd0, valid}, 32'd0);
        check_output("midreset.perr", {31'd0, perr}, 32'd0);
        check_output("midreset.ferr", {31'd0, ferr}, 32'd0);
        check_output("midreset.busy", {31'd0, busy}, 32'd0);
        ticks(3);
        rst = 1'b1;
        ticks(8 * B);
        check_output("midreset.no_valid", valid_count, vc);
        apply_stimulus(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2 * B);
        expect_frame("after_reset", 8'h81, 1'b0, 1'b0, at);

        // Back-to-back frames as an ideal transmitter would send them.
        for (int m = 0; m < 4; m++) begin
            logic [7:0] seq [3];
            seq[0] = 8'h00;
            seq[1] = 8'hFF;
            seq[2] = 8'h5A;
            p_i  = bit'(m / 2);
            pe_i = bit'(m % 2);
            for (int k = 0; k < 3; k++) begin
                apply_stimulus(seq[k], p_i, pe_i, model_parity_bit(seq[k], pe_i), 1'b1);
            end
            idle(2 * B);
            for (int k = 0; k < 3; k++) begin
                expect_frame($sformatf("b2b_m%0d_k%0d", m, k), seq[k], 1'b0, 1'b0, at);
            end
        end

        // Randomized frames against the reference model.
        for (int i = 0; i < 30; i++) begin
            d    = 8'($urandom);
            p_i  = bit'($urandom_range(0, 1));
            pe_i = bit'($urandom_range(0, 1));
            pb   = bit'($urandom_range(0, 1));
            sb   = ($urandom_range(0, 4) != 0);
            apply_stimulus(d, p_i, pe_i, pb, sb);
            idle(2 * B);
            expect_frame($sformatf("rand%0d", i), d, model_perr(d, p_i, pe_i, pb), !sb, at);
        end

        ticks(B);
        check_output("total_valid", valid_count, frames_expected);
        check_output("queue_empty", obsq.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
